// File: rtl/lcd_frame_sched_if.sv
// Scheduler <-> SPI transmitter / pixel source bundle.
// master = frame scheduler, slave = transmitter plus pixel source side.
interface lcd_frame_sched_if;
    logic        o_tx_we;
    logic        o_tx_mode;
    logic [15:0] o_tx_data;
    logic        i_tx_init_done;
    logic        i_tx_running;
    logic        o_pix_req;
    logic [7:0]  o_pix_x;
    logic [7:0]  o_pix_y;
    logic [15:0] i_pix_data;
    logic        i_pix_vld;

    modport master (
        output o_tx_we, o_tx_mode, o_tx_data,
        output o_pix_req, o_pix_x, o_pix_y,
        input  i_tx_init_done, i_tx_running,
        input  i_pix_data, i_pix_vld
    );

    modport slave (
        input  o_tx_we, o_tx_mode, o_tx_data,
        input  o_pix_req, o_pix_x, o_pix_y,
        output i_tx_init_done, i_tx_running,
        output i_pix_data, i_pix_vld
    );
endinterface

// File: rtl/lcd_frame_sched.sv
// SPI LCD frame sequencer: CASET/RASET/RAMWR preamble, then credit-paced pixels.
// Optional internal colour-bar source: LCD_SCHED_TEST_PATTERN_EN.
module lcd_frame_sched #(
    parameter int H_ACTIVE     = 128,
    parameter int V_ACTIVE     = 160,
    parameter int X_OFS        = 0,
    parameter int Y_OFS        = 0,
    parameter int FIFO_DEPTH   = 256,
    parameter int DRAIN_PERIOD = 32,
    parameter int DRAIN_QUAL   = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_en,
    input  logic i_start,
`ifdef LCD_SCHED_TEST_PATTERN_EN
    input  logic i_pattern,
`endif
    output logic o_busy,
    output logic o_frame_done,
    lcd_frame_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, CMD, CMD_DRAIN, PIX, PIX_DRAIN, DONE
    } state_t;

    localparam logic [7:0]  XS       = 8'(X_OFS);
    localparam logic [7:0]  XE       = 8'(X_OFS + H_ACTIVE - 1);
    localparam logic [7:0]  YS       = 8'(Y_OFS);
    localparam logic [7:0]  YE       = 8'(Y_OFS + V_ACTIVE - 1);
    localparam logic [7:0]  XMAX     = 8'(H_ACTIVE - 1);
    localparam logic [7:0]  YMAX     = 8'(V_ACTIVE - 1);
    localparam logic [8:0]  FULL     = 9'(FIFO_DEPTH);
    localparam logic [15:0] PER_MAX  = 16'(DRAIN_PERIOD - 1);
    localparam logic [7:0]  QUAL_MAX = 8'(DRAIN_QUAL - 1);

    state_t      state_q, state_d;
    logic [8:0]  credits_q, credits_d;
    logic [15:0] per_q, per_d;
    logic [7:0]  qual_q, qual_d;
    logic [3:0]  widx_q, widx_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        we_q, we_d;
    logic        mode_q, mode_d;
    logic [15:0] data_q, data_d;
    logic        req_q, req_d;
    logic        pend_q, pend_d;
    logic [15:0] pdata_q, pdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pat_q, pat_d;

    logic        ret, drained, drain_done, adv, can_wr;
    logic [15:0] cmd_word;
    logic [15:0] pat_px;

    always_comb begin
        case (widx_q)
            4'd0:    cmd_word = 16'h2A00;
            4'd2:    cmd_word = {XS, 8'h01};
            4'd4:    cmd_word = {XE, 8'h01};
            4'd5:    cmd_word = 16'h2B00;
            4'd7:    cmd_word = {YS, 8'h01};
            4'd9:    cmd_word = {YE, 8'h01};
            4'd10:   cmd_word = 16'h2C00;
            default: cmd_word = 16'h0001;
        endcase
    end

`ifdef LCD_SCHED_TEST_PATTERN_EN
    logic [10:0] bar;

    always_comb begin
        bar = {x_q, 3'b000} / 11'(H_ACTIVE);
        case (bar)
            11'd0:   pat_px = 16'hFFFF;
            11'd1:   pat_px = 16'hFFE0;
            11'd2:   pat_px = 16'h07FF;
            11'd3:   pat_px = 16'h07E0;
            11'd4:   pat_px = 16'hF81F;
            11'd5:   pat_px = 16'hF800;
            11'd6:   pat_px = 16'h001F;
            default: pat_px = 16'h0000;
        endcase
    end
`else
    assign pat_px = 16'h0000;
`endif

    // A strobe-free cycle is required between writes.
    assign can_wr  = !we_q && (credits_q != 9'd0);
    assign drained = !bus.i_tx_running && !we_q && (qual_q == QUAL_MAX);

    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        per_d      = per_q;
        qual_d     = qual_q;
        widx_d     = widx_q;
        x_d        = x_q;
        y_d        = y_q;
        we_d       = 1'b0;
        mode_d     = mode_q;
        data_d     = data_q;
        req_d      = req_q;
        pend_d     = pend_q;
        pdata_d    = pdata_q;
        done_d     = 1'b0;
        pat_d      = pat_q;
        ret        = 1'b0;
        drain_done = 1'b0;
        adv        = 1'b0;

        if (bus.i_tx_running) begin
            if (per_q == PER_MAX) begin
                per_d = 16'd0;
                ret   = 1'b1;
            end else begin
                per_d = per_q + 16'd1;
            end
        end

        if (bus.i_tx_running || we_q) begin
            qual_d = 8'd0;
        end else if (qual_q != QUAL_MAX) begin
            qual_d = qual_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                x_d    = 8'd0;
                y_d    = 8'd0;
                widx_d = 4'd0;
                req_d  = 1'b0;
                pend_d = 1'b0;
                if (i_start && i_en) begin
                    state_d = WAIT_INIT;
`ifdef LCD_SCHED_TEST_PATTERN_EN
                    pat_d   = i_pattern;
`else
                    pat_d   = 1'b0;
`endif
                end
            end
            WAIT_INIT: begin
                if (bus.i_tx_init_done) state_d = CMD;
            end
            CMD: begin
                if (can_wr) begin
                    we_d   = 1'b1;
                    data_d = cmd_word;
                    if (widx_q == 4'd10) begin
                        widx_d  = 4'd0;
                        state_d = CMD_DRAIN;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            CMD_DRAIN: begin
                if (drained) begin
                    drain_done = 1'b1;
                    mode_d     = 1'b1;
                    state_d    = PIX;
                end
            end
            PIX: begin
                if (pat_q) begin
                    if (can_wr) begin
                        we_d   = 1'b1;
                        data_d = pat_px;
                        adv    = 1'b1;
                    end
                end else if (pend_q) begin
                    if (can_wr) begin
                        we_d   = 1'b1;
                        data_d = pdata_q;
                        pend_d = 1'b0;
                        adv    = 1'b1;
                    end
                end else if (req_q) begin
                    if (bus.i_pix_vld) begin
                        req_d   = 1'b0;
                        pend_d  = 1'b1;
                        pdata_d = bus.i_pix_data;
                    end
                end else begin
                    req_d = 1'b1;
                end
                if (adv) begin
                    if (x_q == XMAX) begin
                        x_d = 8'd0;
                        y_d = y_q + 8'd1;
                        if (y_q == YMAX) state_d = PIX_DRAIN;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            PIX_DRAIN: begin
                if (drained) begin
                    drain_done = 1'b1;
                    mode_d     = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (we_d && !ret) begin
            credits_d = credits_q - 9'd1;
        end else if (ret && !we_d && credits_q != FULL) begin
            credits_d = credits_q + 9'd1;
        end
        if (drain_done) credits_d = FULL;

        // Abort wins over everything, including a pending frame-done.
        if (!i_en) begin
            state_d   = IDLE;
            we_d      = 1'b0;
            mode_d    = 1'b0;
            req_d     = 1'b0;
            pend_d    = 1'b0;
            x_d       = 8'd0;
            y_d       = 8'd0;
            widx_d    = 4'd0;
            credits_d = FULL;
            per_d     = 16'd0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            credits_q <= FULL;
            per_q     <= 16'd0;
            qual_q    <= 8'd0;
            widx_q    <= 4'd0;
            x_q       <= 8'd0;
            y_q       <= 8'd0;
            we_q      <= 1'b0;
            mode_q    <= 1'b0;
            data_q    <= 16'h0000;
            req_q     <= 1'b0;
            pend_q    <= 1'b0;
            pdata_q   <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            per_q     <= per_d;
            qual_q    <= qual_d;
            widx_q    <= widx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            we_q      <= we_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            pdata_q   <= pdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pat_q     <= pat_d;
        end
    end

    assign bus.o_tx_we   = we_q;
    assign bus.o_tx_mode = mode_q;
    assign bus.o_tx_data = data_q;
    assign bus.o_pix_req = req_q;
    assign bus.o_pix_x   = x_q;
    assign bus.o_pix_y   = y_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Directed bench for lcd_frame_sched: preamble, drain, credits, abort.
// Small frame 4x2 at offset (2,1) with a 5-entry FIFO to exercise stalls.
module tb_lcd_frame_sched;

    logic clk;
    logic resetn;
    logic i_en;
    logic i_start;
    logic o_busy;
    logic o_frame_done;
`ifdef LCD_SCHED_TEST_PATTERN_EN
    logic i_pattern;
`endif

    lcd_frame_sched_if bus();

    lcd_frame_sched #(
        .H_ACTIVE(4), .V_ACTIVE(2), .X_OFS(2), .Y_OFS(1),
        .FIFO_DEPTH(5), .DRAIN_PERIOD(32), .DRAIN_QUAL(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_en(i_en),
        .i_start(i_start),
`ifdef LCD_SCHED_TEST_PATTERN_EN
        .i_pattern(i_pattern),
`endif
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int b2b = 0;
    logic prev_we = 1'b0;
    logic [16:0] wq[$];
    int wt[$];

    logic [15:0] cmdw [11] = '{
        16'h2A00, 16'h0001, 16'h0201, 16'h0001, 16'h0501,
        16'h2B00, 16'h0001, 16'h0101, 16'h0001, 16'h0201,
        16'h2C00
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_tx_we === 1'b1) begin
            wq.push_back({bus.o_tx_mode, bus.o_tx_data});
            wt.push_back(cyc);
            if (prev_we) b2b++;
        end
        prev_we = (bus.o_tx_we === 1'b1);
        if (o_frame_done === 1'b1) fd_cnt++;
    end

    function automatic logic [15:0] pv(input logic [7:0] x, input logic [7:0] y);
        return {y, x} ^ 16'hA55A;
    endfunction

    // Pixel source with 0..20 cycle latency.
    initial begin
        int lat;
        bus.i_pix_vld  = 1'b0;
        bus.i_pix_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.o_pix_req === 1'b1) begin
                lat = $urandom_range(0, 20);
                repeat (lat) @(negedge clk);
                bus.i_pix_data = pv(bus.o_pix_x, bus.o_pix_y);
                bus.i_pix_vld  = 1'b1;
                @(negedge clk);
                bus.i_pix_vld  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("write_budget", 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        int k;
        int base;
        resetn = 1'b0;
        i_en = 1'b1;
        i_start = 1'b0;
`ifdef LCD_SCHED_TEST_PATTERN_EN
        i_pattern = 1'b0;
`endif
        bus.i_tx_init_done = 1'b0;
        bus.i_tx_running = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.o_tx_we), 32'd0);
        chk("rst_mode", 32'(bus.o_tx_mode), 32'd0);
        chk("rst_data", 32'(bus.o_tx_data), 32'd0);
        chk("rst_req", 32'(bus.o_pix_req), 32'd0);
        chk("rst_x", 32'(bus.o_pix_x), 32'd0);
        chk("rst_y", 32'(bus.o_pix_y), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_fd", 32'(o_frame_done), 32'd0);
        resetn = 1'b1;

        // Start without init done: busy, but no writes.
        pulse_start();
        repeat (10) @(negedge clk);
        chk("wait_init_busy", 32'(o_busy), 32'd1);
        chk("wait_init_nowr", 32'(wq.size()), 32'd0);

        // Preamble, transmitter running so credits trickle back.
        bus.i_tx_running = 1'b1;
        bus.i_tx_init_done = 1'b1;
        wait_writes(11, 1000);
        for (int i = 0; i < 11; i++)
            chk($sformatf("cmd%0d", i), 32'(wq[i]), {15'd0, 1'b0, cmdw[i]});

        // Still running: no mode switch, no request.
        repeat (200) @(negedge clk);
        chk("hold_mode", 32'(bus.o_tx_mode), 32'd0);
        chk("hold_req", 32'(bus.o_pix_req), 32'd0);
        chk("hold_wr", 32'(wq.size()), 32'd11);
        bus.i_tx_running = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("qual_early", 32'(bus.o_tx_mode), 32'd0);
        @(posedge clk);
        #1 chk("qual_switch", 32'(bus.o_tx_mode), 32'd1);

        // No credit return: exactly FIFO_DEPTH pixel writes.
        repeat (400) @(negedge clk);
        chk("stall_count", 32'(wq.size()), 32'd16);
        chk("stall_noreq", 32'(bus.o_pix_req), 32'd0);
        bus.i_tx_running = 1'b1;
        wait_writes(19, 600);
        chk("pace_a", 32'(wt[17] - wt[16]), 32'd32);
        chk("pace_b", 32'(wt[18] - wt[17]), 32'd32);
        for (int i = 0; i < 8; i++)
            chk($sformatf("pix%0d", i), 32'(wq[11 + i]),
                {15'd0, 1'b1, pv(8'(i % 4), 8'(i / 4))});

        bus.i_tx_running = 1'b0;
        k = 0;
        while (fd_cnt == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("frame_done", 32'(fd_cnt), 32'd1);
        chk("end_mode", 32'(bus.o_tx_mode), 32'd0);
        chk("end_busy", 32'(o_busy), 32'd0);
        chk("end_wr", 32'(wq.size()), 32'd19);

        // Second frame, aborted at pixel (2,1).
        bus.i_tx_running = 1'b1;
        pulse_start();
        wait_writes(30, 1000);
        bus.i_tx_running = 1'b0;
        repeat (6) @(negedge clk);
        chk("f2_mode", 32'(bus.o_tx_mode), 32'd1);
        bus.i_tx_running = 1'b1;
        k = 0;
        while (!(bus.o_pix_req === 1'b1 && bus.o_pix_x == 8'd2 &&
                 bus.o_pix_y == 8'd1) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach", 32'(k < 1000), 32'd1);
        i_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_mode", 32'(bus.o_tx_mode), 32'd0);
        chk("abort_req", 32'(bus.o_pix_req), 32'd0);
        chk("abort_x", 32'(bus.o_pix_x), 32'd0);
        chk("abort_y", 32'(bus.o_pix_y), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_nofd", 32'(fd_cnt), 32'd1);

        // Restart replays the full preamble.
        i_en = 1'b1;
        base = wq.size();
        pulse_start();
        wait_writes(base + 11, 1000);
        for (int i = 0; i < 11; i++)
            chk($sformatf("replay%0d", i), 32'(wq[base + i]),
                {15'd0, 1'b0, cmdw[i]});
        chk("spacing", 32'(b2b), 32'd0);

        i_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
